multicycle_control_unit: RTL and testbench

- Moore/Mealy FSM that sequences the multi-cycle XM datapath for every instruction: fetch, decode, execute, memory and writeback.
- Drives the instruction decoder's `en`.
- Consumes the decoder's `operation` and `alu_no_wb` fields plus a condition-evaluation result.
- Issues all register-file, PC, ALU and memory strobes.
- Provides a memory-wait timeout fault and a retired-instruction counter.

---
 rtl/multicycle_control_unit_if.sv | 38 +++
 rtl/multicycle_control_unit.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Handshake bundle between the multi-cycle control unit (master) and the XM datapath (slave).
// The master drives the strobes, state, fault and count; the slave drives decode and memory status.
interface multicycle_control_unit_if #(
   parameter int CNT_W = 16
);
   logic             run;
   logic [2:0]       operation;
   logic             alu_no_wb;
   logic             cond_true;
   logic             mem_ready;
   logic             en;
   logic             ir_load;
   logic             pc_inc;
   logic             pc_load;
   logic             lr_save;
   logic             alu_en;
   logic             addr_calc;
   logic             mem_rd;
   logic             mem_wr;
   logic             addr_src_pc;
   logic             reg_wb;
   logic [1:0]       wb_sel;
   logic [2:0]       state;
   logic             fault;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  run, operation, alu_no_wb, cond_true, mem_ready,
      output en, ir_load, pc_inc, pc_load, lr_save, alu_en, addr_calc,
             mem_rd, mem_wr, addr_src_pc, reg_wb, wb_sel, state, fault, instr_count
   );

   modport slave (
      output run, operation, alu_no_wb, cond_true, mem_ready,
      input  en, ir_load, pc_inc, pc_load, lr_save, alu_en, addr_calc,
             mem_rd, mem_wr, addr_src_pc, reg_wb, wb_sel, state, fault, instr_count
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Sequencer for the multi-cycle XM datapath: fetch, decode, execute, memory and writeback,
// with a memory-wait timeout that locks into FAULT and a wrapping retired-instruction counter.
module multicycle_control_unit #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input logic                        clk,
   input logic                        reset,
   multicycle_control_unit_if.master  bus
);

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      MEM     = 3'd3,
      WB      = 3'd4,
      IDLE    = 3'd5,
      FAULT   = 3'd7
   } state_e;

   localparam logic [2:0] OP_BL   = 3'd0;
   localparam logic [2:0] OP_BCC  = 3'd1;
   localparam logic [2:0] OP_ALU  = 3'd2;
   localparam logic [2:0] OP_LD   = 3'd3;
   localparam logic [2:0] OP_STR  = 3'd4;
   localparam logic [2:0] OP_LDR  = 3'd5;
   localparam logic [2:0] OP_ST   = 3'd6;
   localparam logic [2:0] OP_MOVX = 3'd7;

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [2:0]         op_q, op_d;
   logic               noWb_q, noWb_d;
   logic               retire;
   logic               timeoutHit;
   logic               opqIsStore;
   state_e             nextFetch;

   // Last tolerated wait cycle: one more cycle without mem_ready ends in FAULT.
   assign timeoutHit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);
   assign opqIsStore = (op_q == OP_STR) || (op_q == OP_ST);
   assign nextFetch  = bus.run ? FETCH : IDLE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wait_q  <= '0;
         count_q <= '0;
         op_q    <= '0;
         noWb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         count_q <= count_d;
         op_q    <= op_d;
         noWb_q  <= noWb_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      op_d            = op_q;
      noWb_d          = noWb_q;
      retire          = 1'b0;
      bus.en          = 1'b0;
      bus.ir_load     = 1'b0;
      bus.pc_inc      = 1'b0;
      bus.pc_load     = 1'b0;
      bus.lr_save     = 1'b0;
      bus.alu_en      = 1'b0;
      bus.addr_calc   = 1'b0;
      bus.mem_rd      = 1'b0;
      bus.mem_wr      = 1'b0;
      bus.addr_src_pc = 1'b0;
      bus.reg_wb      = 1'b0;
      bus.wb_sel      = 2'd0;
      bus.fault       = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.run) state_d = FETCH;
         end
         FETCH: begin
            bus.mem_rd      = 1'b1;
            bus.addr_src_pc = 1'b1;
            if (bus.mem_ready) begin
               bus.ir_load = 1'b1;
               bus.pc_inc  = 1'b1;
               state_d     = DECODE;
            end else if (timeoutHit) begin
               state_d = FAULT;
            end
         end
         DECODE: begin
            bus.en  = 1'b1;
            state_d = EXECUTE;
         end
         EXECUTE: begin
            // The op is captured here so later decoder activity cannot disturb MEM/WB.
            op_d   = bus.operation;
            noWb_d = bus.alu_no_wb;
            case (bus.operation)
               OP_BL: begin
                  bus.lr_save = 1'b1;
                  bus.pc_load = 1'b1;
                  state_d     = nextFetch;
                  retire      = 1'b1;
               end
               OP_BCC: begin
                  bus.pc_load = bus.cond_true;
                  state_d     = nextFetch;
                  retire      = 1'b1;
               end
               OP_ALU: begin
                  bus.alu_en = 1'b1;
                  state_d    = WB;
               end
               OP_LD, OP_STR, OP_LDR, OP_ST: begin
                  bus.addr_calc = 1'b1;
                  state_d       = MEM;
               end
               default: state_d = WB;
            endcase
         end
         MEM: begin
            bus.mem_rd = ~opqIsStore;
            bus.mem_wr = opqIsStore;
            if (bus.mem_ready) begin
               if (opqIsStore) begin
                  state_d = nextFetch;
                  retire  = 1'b1;
               end else begin
                  state_d = WB;
               end
            end else if (timeoutHit) begin
               state_d = FAULT;
            end
         end
         WB: begin
            case (op_q)
               OP_ALU: begin
                  bus.reg_wb = ~noWb_q;
                  bus.wb_sel = 2'd0;
               end
               OP_LD, OP_LDR: begin
                  bus.reg_wb = 1'b1;
                  bus.wb_sel = 2'd1;
               end
               OP_MOVX: begin
                  bus.reg_wb = 1'b1;
                  bus.wb_sel = 2'd2;
               end
               default: bus.reg_wb = 1'b0;
            endcase
            state_d = nextFetch;
            retire  = 1'b1;
         end
         FAULT: begin
            bus.fault = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Wait counter restarts on every state change, so entering FETCH or MEM always begins at zero.
   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q) begin
         wait_d = '0;
      end else if (((state_q == FETCH) || (state_q == MEM)) && !bus.mem_ready) begin
         wait_d = wait_q + 1'b1;
      end
   end

   always_comb begin
      count_d = count_q;
      if (retire) count_d = count_q + 1'b1;
   end

   assign bus.state       = state_q;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench for multicycle_control_unit with MEM_TIMEOUT=4 and CNT_W=4
// so the timeout and the counter wrap are both reachable in a short run.
module tb_multicycle_control_unit;

   logic clk;
   logic reset;

   multicycle_control_unit_if #(.CNT_W(4)) bus ();

   multicycle_control_unit #(
      .MEM_TIMEOUT(4),
      .CNT_W      (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct packed {
      logic [2:0]  st;
      logic [13:0] strb;
      logic [3:0]  cnt;
   } exp_t;

   localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3;
   localparam logic [2:0] S_W = 3'd4, S_I = 3'd5, S_X = 3'd7;

   // Strobe vector order: en ir_load pc_inc pc_load lr_save alu_en addr_calc mem_rd mem_wr addr_src_pc reg_wb wb_sel[1:0] fault
   localparam logic [13:0] M_EN  = 14'h2000, M_IRL = 14'h1000, M_PCI = 14'h0800, M_PCL = 14'h0400;
   localparam logic [13:0] M_LR  = 14'h0200, M_ALU = 14'h0100, M_AC  = 14'h0080, M_RD  = 14'h0040;
   localparam logic [13:0] M_WR  = 14'h0020, M_APC = 14'h0010, M_RWB = 14'h0008, M_WB2 = 14'h0004;
   localparam logic [13:0] M_WB1 = 14'h0002, M_FLT = 14'h0001, M_NONE = 14'h0000;
   localparam logic [13:0] FR = M_RD | M_APC | M_IRL | M_PCI;
   localparam logic [13:0] FW = M_RD | M_APC;

   exp_t scoreQ[$];
   int   passCount  = 0;
   int   checkCount = 0;
   int   stepNo     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic pushExpected(input logic [2:0] st, input logic [13:0] strb, input logic [3:0] cnt);
      exp_t e;
      e.st   = st;
      e.strb = strb;
      e.cnt  = cnt;
      scoreQ.push_back(e);
   endtask

   task automatic checkOutput(input string tag);
      exp_t        e;
      logic [13:0] obsStrb;
      e = scoreQ.pop_front();
      obsStrb = {bus.en, bus.ir_load, bus.pc_inc, bus.pc_load, bus.lr_save, bus.alu_en,
                 bus.addr_calc, bus.mem_rd, bus.mem_wr, bus.addr_src_pc, bus.reg_wb,
                 bus.wb_sel, bus.fault};
      checkCount++;
      assert (bus.state === e.st) passCount++;
      else $error("[TB] FAIL %s state: observed %0d expected %0d", tag, bus.state, e.st);
      checkCount++;
      assert (obsStrb === e.strb) passCount++;
      else $error("[TB] FAIL %s strobes: observed %h expected %h", tag, obsStrb, e.strb);
      checkCount++;
      assert (bus.instr_count === e.cnt) passCount++;
      else $error("[TB] FAIL %s instr_count: observed %0d expected %0d", tag, bus.instr_count, e.cnt);
   endtask

   // One clock cycle: drive inputs after the falling edge, check the outputs of that cycle before the rising edge.
   task automatic applyStimulus(input logic r, input logic [2:0] op, input logic nw, input logic cond,
                                input logic rdy, input logic [2:0] st, input logic [13:0] strb,
                                input logic [3:0] cnt);
      @(negedge clk);
      bus.run       = r;
      bus.operation = op;
      bus.alu_no_wb = nw;
      bus.cond_true = cond;
      bus.mem_ready = rdy;
      pushExpected(st, strb, cnt);
      stepNo++;
      #1;
      checkOutput($sformatf("step%0d", stepNo));
   endtask

   task automatic doReset();
      bus.run       = 1'b0;
      bus.operation = 3'd0;
      bus.alu_no_wb = 1'b0;
      bus.cond_true = 1'b0;
      bus.mem_ready = 1'b0;
      reset         = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] c;
      reset         = 1'b1;
      bus.run       = 1'b0;
      bus.operation = 3'd0;
      bus.alu_no_wb = 1'b0;
      bus.cond_true = 1'b0;
      bus.mem_ready = 1'b0;
      #3;
      pushExpected(S_I, M_NONE, 4'd0);
      checkOutput("resetState");
      doReset();

      // ALU with writeback
      applyStimulus(1, 3'd2, 0, 0, 1, S_I, M_NONE, 4'd0);
      applyStimulus(1, 3'd2, 0, 0, 1, S_F, FR,     4'd0);
      applyStimulus(1, 3'd2, 0, 0, 1, S_D, M_EN,   4'd0);
      applyStimulus(1, 3'd2, 0, 0, 1, S_E, M_ALU,  4'd0);
      applyStimulus(1, 3'd2, 0, 0, 1, S_W, M_RWB,  4'd0);
      // CMP: no register write
      applyStimulus(1, 3'd2, 1, 0, 1, S_F, FR,     4'd1);
      applyStimulus(1, 3'd2, 1, 0, 1, S_D, M_EN,   4'd1);
      applyStimulus(1, 3'd2, 1, 0, 1, S_E, M_ALU,  4'd1);
      applyStimulus(1, 3'd2, 1, 0, 1, S_W, M_NONE, 4'd1);
      // Bcc not taken, then taken
      applyStimulus(1, 3'd1, 0, 0, 1, S_F, FR,     4'd2);
      applyStimulus(1, 3'd1, 0, 0, 1, S_D, M_EN,   4'd2);
      applyStimulus(1, 3'd1, 0, 0, 1, S_E, M_NONE, 4'd2);
      applyStimulus(1, 3'd1, 0, 1, 1, S_F, FR,     4'd3);
      applyStimulus(1, 3'd1, 0, 1, 1, S_D, M_EN,   4'd3);
      applyStimulus(1, 3'd1, 0, 1, 1, S_E, M_PCL,  4'd3);
      // BL
      applyStimulus(1, 3'd0, 0, 0, 1, S_F, FR,            4'd4);
      applyStimulus(1, 3'd0, 0, 0, 1, S_D, M_EN,          4'd4);
      applyStimulus(1, 3'd0, 0, 0, 1, S_E, M_PCL | M_LR,  4'd4);
      // LDR with three wait cycles; operation input changes after decode and must be ignored
      applyStimulus(1, 3'd5, 0, 0, 1, S_F, FR,            4'd5);
      applyStimulus(1, 3'd5, 0, 0, 1, S_D, M_EN,          4'd5);
      applyStimulus(1, 3'd5, 0, 0, 1, S_E, M_AC,          4'd5);
      applyStimulus(1, 3'd4, 0, 0, 0, S_M, M_RD,          4'd5);
      applyStimulus(1, 3'd4, 0, 0, 0, S_M, M_RD,          4'd5);
      applyStimulus(1, 3'd4, 0, 0, 0, S_M, M_RD,          4'd5);
      applyStimulus(1, 3'd4, 0, 0, 1, S_M, M_RD,          4'd5);
      applyStimulus(1, 3'd4, 0, 0, 1, S_W, M_RWB | M_WB1, 4'd5);
      // STR
      applyStimulus(1, 3'd4, 0, 0, 1, S_F, FR,   4'd6);
      applyStimulus(1, 3'd4, 0, 0, 1, S_D, M_EN, 4'd6);
      applyStimulus(1, 3'd4, 0, 0, 1, S_E, M_AC, 4'd6);
      applyStimulus(1, 3'd4, 0, 0, 1, S_M, M_WR, 4'd6);
      // MOVx with run dropped during EXECUTE: finishes WB then halts
      applyStimulus(1, 3'd7, 0, 0, 1, S_F, FR,            4'd7);
      applyStimulus(1, 3'd7, 0, 0, 1, S_D, M_EN,          4'd7);
      applyStimulus(0, 3'd7, 0, 0, 1, S_E, M_NONE,        4'd7);
      applyStimulus(0, 3'd7, 0, 0, 1, S_W, M_RWB | M_WB2, 4'd7);
      applyStimulus(0, 3'd7, 0, 0, 1, S_I, M_NONE,        4'd8);
      applyStimulus(1, 3'd7, 0, 0, 1, S_I, M_NONE,        4'd8);

      // Eight BLs take the 4-bit counter from 8 through the wrap to 0
      c = 4'd8;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 3'd0, 0, 0, 1, S_F, FR,           c);
         applyStimulus(1, 3'd0, 0, 0, 1, S_D, M_EN,         c);
         applyStimulus(1, 3'd0, 0, 0, 1, S_E, M_PCL | M_LR, c);
         c = c + 4'd1;
      end
      applyStimulus(1, 3'd0, 0, 0, 1, S_F, FR,           4'd0);
      applyStimulus(1, 3'd0, 0, 0, 1, S_D, M_EN,         4'd0);
      applyStimulus(1, 3'd0, 0, 0, 1, S_E, M_PCL | M_LR, 4'd0);

      // Fetch timeout: four waiting cycles, then FAULT that ignores run/mem_ready
      applyStimulus(1, 3'd0, 0, 0, 0, S_F, FW,    4'd1);
      applyStimulus(1, 3'd0, 0, 0, 0, S_F, FW,    4'd1);
      applyStimulus(1, 3'd0, 0, 0, 0, S_F, FW,    4'd1);
      applyStimulus(1, 3'd0, 0, 0, 0, S_F, FW,    4'd1);
      applyStimulus(1, 3'd0, 0, 0, 1, S_X, M_FLT, 4'd1);
      applyStimulus(1, 3'd0, 0, 0, 1, S_X, M_FLT, 4'd1);
      applyStimulus(1, 3'd0, 0, 0, 1, S_X, M_FLT, 4'd1);
      doReset();
      applyStimulus(0, 3'd0, 0, 0, 1, S_I, M_NONE, 4'd0);

      // One BL, then a store stalled in MEM interrupted by an asynchronous reset
      applyStimulus(1, 3'd0, 0, 0, 1, S_I, M_NONE,       4'd0);
      applyStimulus(1, 3'd0, 0, 0, 1, S_F, FR,           4'd0);
      applyStimulus(1, 3'd0, 0, 0, 1, S_D, M_EN,         4'd0);
      applyStimulus(1, 3'd0, 0, 0, 1, S_E, M_PCL | M_LR, 4'd0);
      applyStimulus(1, 3'd6, 0, 0, 1, S_F, FR,           4'd1);
      applyStimulus(1, 3'd6, 0, 0, 1, S_D, M_EN,         4'd1);
      applyStimulus(1, 3'd6, 0, 0, 1, S_E, M_AC,         4'd1);
      applyStimulus(1, 3'd6, 0, 0, 0, S_M, M_WR,         4'd1);
      #2;
      reset = 1'b1;
      #1;
      pushExpected(S_I, M_NONE, 4'd0);
      checkOutput("asyncReset");
      doReset();
      applyStimulus(0, 3'd0, 0, 0, 0, S_I, M_NONE, 4'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
